// File: rtl/uop_cache_arbiter.sv
// Single-port arbiter/sequencer for the loop-buffer uop cache BRAM: fill writes, replay reads, invalidate sweep.
// Optional statistics counters are enabled with `define UOPC_ARB_STATS_EN.
module uop_cache_arbiter #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_hit,
    input  logic          inv_req,
    output logic          inv_busy,
    output logic          inv_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef UOPC_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   stall_cnt
`endif
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state, next_state;
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    sweep_cnt;
    logic             last_winner;  // 1: write won the last conflict
    logic             rd_hit_q;
    logic             conflict;

    assign conflict = (state == IDLE) && wr_req && rd_req;
    assign inv_busy = (state != IDLE);
    assign inv_done = (state == DONE);
    assign rd_hit   = rd_valid & rd_hit_q;
    assign rd_data  = rd_valid ? mem_rdata : '0;

    always_comb begin
        next_state = state;
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                // Grants are gated so nothing reaches the BRAM while reset is held.
                if (!reset) begin
                    wr_gnt = wr_req && (!rd_req || !last_winner);
                    rd_gnt = rd_req && !wr_gnt;
                    if (wr_gnt) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end else if (rd_gnt) begin
                        mem_en   = 1'b1;
                        mem_addr = rd_addr;
                    end
                    if (inv_req) next_state = SWEEP;
                end
            end
            SWEEP: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sweep_cnt;
                if (sweep_cnt == {AW{1'b1}}) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            sweep_cnt   <= '0;
            last_winner <= 1'b0;
            rd_valid    <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            state    <= next_state;
            rd_valid <= rd_gnt;
            if (rd_gnt) rd_hit_q <= valid[rd_addr];
            if (wr_gnt) valid[wr_addr] <= 1'b1;
            if (state == SWEEP) begin
                valid[sweep_cnt] <= 1'b0;
                sweep_cnt        <= sweep_cnt + 1'b1;
            end
            if (state == IDLE && inv_req) sweep_cnt <= '0;
            if (conflict) last_winner <= wr_gnt;
        end
    end

`ifdef UOPC_ARB_STATS_EN
    logic stall;
    assign stall = (state != IDLE) && (wr_req || rd_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else if (state == DONE) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF)       stall_cnt    <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uop_cache_arbiter.sv
// Directed bench for uop_cache_arbiter: vector table for arbitration/read path, hand sequences for sweep and reset.
module tb_uop_cache_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, rd_req, inv_req;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic        wr_gnt, rd_gnt, rd_valid, rd_hit, inv_busy, inv_done, mem_en, mem_we;
    logic [31:0] rd_data, mem_wdata, mem_rdata;
    logic [2:0]  mem_addr;
`ifdef UOPC_ARB_STATS_EN
    logic [15:0] conflict_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [8];

    always #5 clk = ~clk;

    uop_cache_arbiter #(.AW(3), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit),
        .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef UOPC_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Synchronous-read BRAM model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] wr, wa, wd, rd, ra;
        logic [31:0] wg, rg, en, we, ma, mw, rv, rdat, hit;
    } vec_t;
    vec_t tbl [17];

    task automatic idle_inputs();
        wr_req = 0; rd_req = 0; inv_req = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
    endtask

    task automatic fill_all(input logic [31:0] base);
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            wr_req = 1; wr_addr = 3'(e); wr_data = base + 32'(e);
        end
        @(posedge clk); #1;
        wr_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem_rdata = '0;
        //          wr wa wd            rd ra  wg rg en we ma mw            rv rdat          hit
        tbl[0]  = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            0, 0,            0};
        tbl[1]  = '{1, 3, 32'hDEADBEEF, 0, 0,  1, 0, 1, 1, 3, 32'hDEADBEEF, 0, 0,            0};
        tbl[2]  = '{0, 0, 0,            1, 3,  0, 1, 1, 0, 3, 0,            0, 0,            0};
        tbl[3]  = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 1};
        tbl[4]  = '{0, 0, 0,            1, 5,  0, 1, 1, 0, 5, 0,            0, 0,            0};
        tbl[5]  = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            1, 0,            0};
        tbl[6]  = '{1, 1, 32'h11,       1, 3,  1, 0, 1, 1, 1, 32'h11,       0, 0,            0};
        tbl[7]  = '{1, 1, 32'h11,       1, 3,  0, 1, 1, 0, 3, 0,            0, 0,            0};
        tbl[8]  = '{1, 1, 32'h11,       1, 3,  1, 0, 1, 1, 1, 32'h11,       1, 32'hDEADBEEF, 1};
        tbl[9]  = '{1, 1, 32'h11,       1, 3,  0, 1, 1, 0, 3, 0,            0, 0,            0};
        tbl[10] = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 1};
        tbl[11] = '{0, 0, 0,            1, 1,  0, 1, 1, 0, 1, 0,            0, 0,            0};
        tbl[12] = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            1, 32'h11,       1};
        tbl[13] = '{1, 2, 32'h22,       0, 0,  1, 0, 1, 1, 2, 32'h22,       0, 0,            0};
        tbl[14] = '{1, 4, 32'h44,       1, 2,  1, 0, 1, 1, 4, 32'h44,       0, 0,            0};
        tbl[15] = '{0, 0, 0,            1, 2,  0, 1, 1, 0, 2, 0,            0, 0,            0};
        tbl[16] = '{0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0,            1, 32'h22,       1};

        // Reset values, with requests asserted to show grants stay low
        idle_inputs();
        reset = 1; wr_req = 1; rd_req = 1;
        @(negedge clk);
        chk("rst_wr_gnt",   32'(wr_gnt),   0);
        chk("rst_rd_gnt",   32'(rd_gnt),   0);
        chk("rst_mem_en",   32'(mem_en),   0);
        chk("rst_mem_we",   32'(mem_we),   0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  rd_data,       0);
        chk("rst_inv_busy", 32'(inv_busy), 0);
        chk("rst_inv_done", 32'(inv_done), 0);
        @(posedge clk); #1;
        reset = 0; idle_inputs();

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            wr_req = tbl[i].wr[0]; wr_addr = tbl[i].wa[2:0]; wr_data = tbl[i].wd;
            rd_req = tbl[i].rd[0]; rd_addr = tbl[i].ra[2:0];
            @(negedge clk);
            chk($sformatf("v%0d_wr_gnt", i),    32'(wr_gnt),    tbl[i].wg);
            chk($sformatf("v%0d_rd_gnt", i),    32'(rd_gnt),    tbl[i].rg);
            chk($sformatf("v%0d_mem_en", i),    32'(mem_en),    tbl[i].en);
            chk($sformatf("v%0d_mem_we", i),    32'(mem_we),    tbl[i].we);
            chk($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  tbl[i].ma);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata,      tbl[i].mw);
            chk($sformatf("v%0d_rd_valid", i),  32'(rd_valid),  tbl[i].rv);
            chk($sformatf("v%0d_rd_data", i),   rd_data,        tbl[i].rdat);
            chk($sformatf("v%0d_rd_hit", i),    32'(rd_hit),    tbl[i].hit);
            chk($sformatf("v%0d_inv_busy", i),  32'(inv_busy),  0);
        end
`ifdef UOPC_ARB_STATS_EN
        chk("conflict_cnt_after_table", 32'(conflict_cnt), 5);
        chk("stall_cnt_after_table",    32'(stall_cnt),    0);
`endif

        // Full invalidate sweep with a read held pending
        idle_inputs();
        fill_all(32'h100);
        #0 inv_req = 1;
        @(negedge clk);
        chk("inv_cycle_busy", 32'(inv_busy), 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            inv_req = (k == 3);
            rd_req = 1; rd_addr = 2;
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("sw%0d_busy", k),  32'(inv_busy),  1);
                chk($sformatf("sw%0d_done", k),  32'(inv_done),  0);
                chk($sformatf("sw%0d_en", k),    32'(mem_en),    1);
                chk($sformatf("sw%0d_we", k),    32'(mem_we),    1);
                chk($sformatf("sw%0d_addr", k),  32'(mem_addr),  k);
                chk($sformatf("sw%0d_wdata", k), mem_wdata,      0);
                chk($sformatf("sw%0d_rd_gnt", k), 32'(rd_gnt),   0);
            end else if (k == 8) begin
                chk("done_busy",   32'(inv_busy), 1);
                chk("done_pulse",  32'(inv_done), 1);
                chk("done_rd_gnt", 32'(rd_gnt),   0);
                chk("done_mem_en", 32'(mem_en),   0);
`ifdef UOPC_ARB_STATS_EN
                chk("done_stall_cnt",    32'(stall_cnt),    8);
                chk("done_conflict_cnt", 32'(conflict_cnt), 5);
`endif
            end else begin
                chk("post_busy",     32'(inv_busy), 0);
                chk("post_done",     32'(inv_done), 0);
                chk("post_rd_gnt",   32'(rd_gnt),   1);
                chk("post_mem_addr", 32'(mem_addr), 2);
`ifdef UOPC_ARB_STATS_EN
                chk("post_stall_cnt",    32'(stall_cnt),    0);
                chk("post_conflict_cnt", 32'(conflict_cnt), 0);
`endif
            end
        end
        @(posedge clk); #1;
        rd_req = 0;
        @(negedge clk);
        chk("inv_read_valid", 32'(rd_valid), 1);
        chk("inv_read_hit",   32'(rd_hit),   0);
        chk("inv_read_data",  rd_data,       0);
        chk("inv_no_requeue", 32'(inv_busy), 0);

        // Reset asserted at sweep entry 4
        fill_all(32'h200);
        #0 inv_req = 1; wr_req = 1; wr_addr = 6; wr_data = 32'h66;
        @(negedge clk);
        chk("inv_same_cycle_wr_gnt", 32'(wr_gnt), 1);
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("rs%0d_addr", k), 32'(mem_addr), k);
        end
        reset = 1;
        #1;
        chk("rst_mid_busy",   32'(inv_busy), 0);
        chk("rst_mid_mem_en", 32'(mem_en),   0);
        chk("rst_mid_done",   32'(inv_done), 0);
        @(posedge clk); #1;
        reset = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("rs_no_done%0d", c), 32'(inv_done), 0);
        end
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            rd_req = 1; rd_addr = 3'(e);
            @(posedge clk); #1;
            rd_req = 0;
            @(negedge clk);
            chk($sformatf("rs_rd%0d_valid", e), 32'(rd_valid), 1);
            chk($sformatf("rs_rd%0d_hit", e),   32'(rd_hit),   0);
        end

        // Reset while a read is in flight drops rd_valid
        @(posedge clk); #1;
        rd_req = 1; rd_addr = 0;
        @(negedge clk);
        chk("drop_rd_gnt", 32'(rd_gnt), 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0; rd_req = 0;
        @(negedge clk);
        chk("drop_rd_valid", 32'(rd_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uop_cache_arbiter.md
# uop_cache_arbiter

Single-port arbiter and sequencer for the loop-buffer uop cache memory. It shares one synchronous-read memory port between three requesters: the loop fill path (writes), the replay path (reads) and the invalidate path (full clear on flush/mispredict). It also tracks a valid bit per entry. It sits between the loop-detection FSM and the uop cache BRAM, and is the only block driving the BRAM port.

## Interface
Parameters:
- AW, 3, entry address width; depth = 2^AW entries
- DW, 32, instruction/data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- wr_req  in  1  fill path requests a write
- wr_addr  in  AW  write entry index
- wr_data  in  DW  instruction to store
- wr_gnt  out  1  write granted this cycle (combinational)
- rd_req  in  1  replay path requests a read
- rd_addr  in  AW  read entry index
- rd_gnt  out  1  read granted this cycle (combinational)
- rd_valid  out  1  registered; read data valid, one cycle after rd_gnt
- rd_data  out  DW  read data, qualified by rd_valid
- rd_hit  out  1  valid bit of the read entry, sampled at grant, qualified by rd_valid
- inv_req  in  1  request a full invalidate sweep
- inv_busy  out  1  high in SWEEP and DONE
- inv_done  out  1  one-cycle pulse at sweep completion
- mem_en, mem_we  out  1 each  BRAM port enable / write enable
- mem_addr  out  AW  BRAM address
- mem_wdata  out  DW  BRAM write data
- mem_rdata  in  DW  BRAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- FSM states IDLE, SWEEP, DONE. Reset state is IDLE.
- IDLE:
  - wr_req and rd_req are arbitrated.
  - A lone requester is granted.
  - If both request, the winner is the side that did not win the previous conflict. A 1-bit last_winner register tracks this; after reset it is 0, so write wins the first conflict.
  - last_winner updates only on conflict cycles.
- Write grant: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; valid[wr_addr] is set at the edge.
- Read grant: mem_en=1, mem_we=0, mem_addr=rd_addr; valid[rd_addr] is captured for rd_hit.
- No grant: mem_en=0, mem_we=0; mem_addr and mem_wdata are 0.
- inv_req in IDLE:
  - Normal arbitration still happens in that cycle.
  - The next state is SWEEP and the sweep counter is set to 0.
- SWEEP:
  - wr_gnt=rd_gnt=0.
  - Each cycle: mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=0, and valid[counter] is cleared.
  - Counter increments; after entry 2^AW-1 the next state is DONE.
- DONE: one cycle; inv_done=1, no grants; next state is IDLE.
- inv_req while in SWEEP or DONE is ignored (not queued).
- A reset asserted mid-sweep:
  - FSM returns to IDLE and all valid bits clear immediately.
  - inv_done does not pulse.
  - An outstanding rd_valid is dropped.
- Requesters must hold req until they see gnt. Addresses are always in range because depth = 2^AW.

## Timing
- Grants are combinational from req and state, same cycle.
- Read latency is 1 cycle: rd_valid is asserted in the cycle after rd_gnt, with rd_data=mem_rdata and rd_hit as sampled.
- A write in cycle N followed by a read of the same entry in N+1 returns the new data with rd_hit=1.
- Sweep length is exactly 2^AW cycles, then DONE for 1 cycle. Total busy time is 2^AW+1 cycles, starting the cycle after inv_req is sampled.
- Reset values:
  - wr_gnt, rd_gnt, rd_valid, rd_hit, inv_busy, inv_done, mem_en, mem_we = 0
  - rd_data, mem_addr, mem_wdata = 0
  - all valid bits = 0, last_winner = 0

## Configuration
- UOPC_ARB_STATS_EN defined:
  - Adds output conflict_cnt[15:0], which increments on every cycle where wr_req and rd_req are both high in IDLE.
  - Adds output stall_cnt[15:0], which increments on every cycle a request is pending while in SWEEP or DONE.
  - Both counters saturate at 16'hFFFF and clear on reset and on inv_done.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

## Test plan
- Fill/read: write 0xDEADBEEF to entry 3, then read entry 3 the next cycle. Expect rd_valid the following cycle with rd_data=0xDEADBEEF, rd_hit=1.
- Miss: after reset, read entry 5. Expect rd_valid=1, rd_hit=0.
- Conflict fairness: hold wr_req and rd_req high for 4 cycles after reset. Expect grants W, R, W, R; conflict_cnt=4 with UOPC_ARB_STATS_EN.
- Invalidate, AW=3:
  - Sequence: fill entries 0–7, pulse inv_req, hold rd_req.
  - Expect inv_busy for 9 cycles and mem_addr 0..7 with mem_we=1 and mem_wdata=0.
  - Expect inv_done in cycle 9 and no rd_gnt until the cycle after.
  - The subsequent read of entry 2 returns rd_hit=0.
- Reset mid-sweep: assert reset at sweep entry 4. Expect immediate IDLE, inv_busy=0, no inv_done, all rd_hit=0 afterwards.
